// File: rtl/riscv_run_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_run_sequencer
// Run controller for NUM_HARTS pipelined RV32I cores. It pulses the cores'
// reset, counts run cycles and snoops each hart's store bus for the TOHOST
// completion write. It then reports pass, fail or timeout, together with the
// first failing hart and its code.
//
// Ports
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_start          pulse: begin a run (accepted in IDLE or DONE)
//   i_timeout        run-cycle limit, 0 = unlimited, latched on start
//   o_core_rstn      active-low reset to each core
//   i_wr_valid/addr/data  per-hart store bus, hart h at [h*W +: W]
//   o_busy, o_done   RESET/RUN, DONE status
//   o_pass, o_timeout     verdict, valid with o_done
//   o_hart_done      per-hart completion seen this run
//   o_fail_hart      one-hot first failing hart
//   o_fail_code      first failure code (data >> 1)
//   o_cycles         run-cycle count (saturating)
// -----------------------------------------------------------------------------
module riscv_run_sequencer #(
    parameter int                NUM_HARTS   = 1,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 2,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [CNT_W-1:0]            i_timeout,
    output logic [NUM_HARTS-1:0]        o_core_rstn,
    input  logic [NUM_HARTS-1:0]        i_wr_valid,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_HARTS*DATA_W-1:0] i_wr_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic                        o_timeout,
    output logic [NUM_HARTS-1:0]        o_hart_done,
    output logic [NUM_HARTS-1:0]        o_fail_hart,
    output logic [DATA_W-1:0]           o_fail_code,
    output logic [CNT_W-1:0]            o_cycles
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    logic [RC_W-1:0]      rst_cnt_r;
    logic [CNT_W-1:0]     limit_r;
    logic [NUM_HARTS-1:0] core_rstn_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic                 timeout_r;
    logic [NUM_HARTS-1:0] hart_done_r;
    logic [NUM_HARTS-1:0] fail_hart_r;
    logic [DATA_W-1:0]    fail_code_r;
    logic [CNT_W-1:0]     cycles_r;

    logic [NUM_HARTS-1:0] hit_s;
    logic [NUM_HARTS-1:0] fail_s;
    logic [NUM_HARTS-1:0] fail_pick_s;
    logic [DATA_W-1:0]    fail_code_s;
    logic [NUM_HARTS-1:0] new_done_s;
    logic                 all_done_s;
    logic                 tmo_hit_s;
    logic [CNT_W-1:0]     cycles_inc_s;

    // Decode completion writes, pick the lowest failing hart and its code.
    always_comb begin
        hit_s       = '0;
        fail_s      = '0;
        fail_code_s = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            hit_s[h]  = i_wr_valid[h] &&
                        (i_wr_addr[h*ADDR_W +: ADDR_W] == TOHOST_ADDR) &&
                        !hart_done_r[h];
            fail_s[h] = hit_s[h] && (i_wr_data[h*DATA_W +: DATA_W] != DATA_W'(1));
        end
        // Isolate the lowest set bit: lowest index wins a same-cycle tie.
        fail_pick_s = fail_s & ~(fail_s - NUM_HARTS'(1));
        for (int h = 0; h < NUM_HARTS; h++) begin
            fail_code_s = fail_code_s |
                          (fail_pick_s[h] ? (i_wr_data[h*DATA_W +: DATA_W] >> 1'b1)
                                          : {DATA_W{1'b0}});
        end
    end

    // Run-completion, timeout and saturating cycle-increment terms.
    always_comb begin
        new_done_s   = hart_done_r | hit_s;
        all_done_s   = &new_done_s;
        tmo_hit_s    = (limit_r != '0) && (cycles_r == (limit_r - CNT_W'(1)));
        cycles_inc_s = (cycles_r == '1) ? cycles_r : (cycles_r + CNT_W'(1));
    end

    // Run-control FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            rst_cnt_r   <= '0;
            limit_r     <= '0;
            core_rstn_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            hart_done_r <= '0;
            fail_hart_r <= '0;
            fail_code_r <= '0;
            cycles_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    core_rstn_r <= '0;
                    if (i_start) begin
                        state_r     <= ST_RESET;
                        rst_cnt_r   <= RC_W'(RST_CYCLES);
                        limit_r     <= i_timeout;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        timeout_r   <= 1'b0;
                        hart_done_r <= '0;
                        fail_hart_r <= '0;
                        fail_code_r <= '0;
                        cycles_r    <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_r <= RC_W'(1)) begin
                        state_r     <= ST_RUN;
                        core_rstn_r <= '1;
                    end else begin
                        rst_cnt_r   <= rst_cnt_r - RC_W'(1);
                        core_rstn_r <= '0;
                    end
                end
                ST_RUN: begin
                    hart_done_r <= new_done_s;
                    // Only the first failure of the run is latched.
                    if ((fail_hart_r == '0) && (fail_s != '0)) begin
                        fail_hart_r <= fail_pick_s;
                        fail_code_r <= fail_code_s;
                    end else begin
                        fail_hart_r <= fail_hart_r;
                    end
                    if (all_done_s) begin
                        // Completion outranks a timeout in the same cycle.
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        core_rstn_r <= '0;
                        pass_r      <= (fail_hart_r == '0) && (fail_s == '0);
                        timeout_r   <= 1'b0;
                        cycles_r    <= cycles_inc_s;
                    end else if (tmo_hit_s) begin
                        // The count stays at limit-1 on the timeout edge.
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        core_rstn_r <= '0;
                        pass_r      <= 1'b0;
                        timeout_r   <= 1'b1;
                    end else begin
                        cycles_r    <= cycles_inc_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    core_rstn_r <= '0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign o_core_rstn = core_rstn_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_pass      = pass_r;
    assign o_timeout   = timeout_r;
    assign o_hart_done = hart_done_r;
    assign o_fail_hart = fail_hart_r;
    assign o_fail_code = fail_code_r;
    assign o_cycles    = cycles_r;

endmodule

// File: tb/tb_riscv_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riscv_run_sequencer
// Three-hart bench for riscv_run_sequencer. Directed runs with hand-computed
// expectations are followed by randomized runs. Every cycle is compared
// against a behavioural run model.
// -----------------------------------------------------------------------------
module tb_riscv_run_sequencer;

    localparam int          NH     = 3;
    localparam int          RSTC   = 2;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    localparam int PH_IDLE  = 0;
    localparam int PH_RESET = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DONE  = 3;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_start = 1'b0;
    logic [31:0]     i_timeout = 32'd0;
    logic [NH-1:0]   o_core_rstn;
    logic [NH-1:0]   i_wr_valid = '0;
    logic [NH*32-1:0] i_wr_addr = '0;
    logic [NH*32-1:0] i_wr_data = '0;
    logic            o_busy, o_done, o_pass, o_timeout;
    logic [NH-1:0]   o_hart_done, o_fail_hart;
    logic [31:0]     o_fail_code, o_cycles;

    riscv_run_sequencer #(
        .NUM_HARTS(NH), .ADDR_W(32), .DATA_W(32), .CNT_W(32),
        .RST_CYCLES(RSTC), .TOHOST_ADDR(TOHOST)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_timeout(i_timeout),
        .o_core_rstn(o_core_rstn), .i_wr_valid(i_wr_valid),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_timeout(o_timeout), .o_hart_done(o_hart_done),
        .o_fail_hart(o_fail_hart), .o_fail_code(o_fail_code),
        .o_cycles(o_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model of one run, in plain run-level terms.
    int          m_phase = PH_IDLE;
    int          m_left  = 0;
    logic [31:0] m_limit = '0;
    logic [NH-1:0] m_rstn = '0, m_hd = '0, m_fh = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_to = 1'b0;
    logic [31:0] m_fc = '0, m_cycles = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NH-1:0] hd_next;
        bit          finished, limit_hit;
        logic [31:0] d;
        if (i_rst) begin
            m_phase = PH_IDLE; m_left = 0; m_limit = '0; m_rstn = '0;
            m_busy = 0; m_done = 0; m_pass = 0; m_to = 0;
            m_hd = '0; m_fh = '0; m_fc = '0; m_cycles = '0;
            return;
        end
        if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
            if (i_start) begin
                m_phase = PH_RESET; m_left = RSTC; m_limit = i_timeout;
                m_busy = 1; m_done = 0; m_pass = 0; m_to = 0;
                m_hd = '0; m_fh = '0; m_fc = '0; m_cycles = '0;
            end
            m_rstn = '0;
        end else if (m_phase == PH_RESET) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = PH_RUN;
                m_rstn  = '1;
            end
        end else begin
            hd_next = m_hd;
            for (int h = 0; h < NH; h++) begin
                d = i_wr_data[h*32 +: 32];
                if (i_wr_valid[h] && i_wr_addr[h*32 +: 32] == TOHOST && !m_hd[h]) begin
                    hd_next[h] = 1'b1;
                    if (d != 32'd1 && m_fh == '0) begin
                        m_fh[h] = 1'b1;
                        m_fc    = d / 2;
                    end
                end
            end
            m_hd      = hd_next;
            finished  = (m_hd == '1);
            limit_hit = (m_limit != 0) && (m_cycles + 1 == m_limit);
            if (finished) begin
                m_phase = PH_DONE; m_busy = 0; m_done = 1; m_rstn = '0;
                m_pass  = (m_fh == '0); m_to = 0;
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            end else if (limit_hit) begin
                m_phase = PH_DONE; m_busy = 0; m_done = 1; m_rstn = '0;
                m_pass  = 0; m_to = 1;
            end else begin
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            end
        end
    endtask

    // Advance the model on every rising edge.
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every output against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("core_rstn", o_core_rstn, m_rstn);
            chk("busy",      o_busy,      m_busy);
            chk("done",      o_done,      m_done);
            chk("pass",      o_pass,      m_pass);
            chk("timeout",   o_timeout,   m_to);
            chk("hart_done", o_hart_done, m_hd);
            chk("fail_hart", o_fail_hart, m_fh);
            chk("fail_code", o_fail_code, m_fc);
            chk("cycles",    o_cycles,    m_cycles);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept a start; returns in the first RUN cycle (o_cycles == 0).
    task automatic start_run(input logic [31:0] lim);
        i_start   = 1'b1;
        i_timeout = lim;
        step(1);
        i_start   = 1'b0;
        i_timeout = $urandom;
        chk("rstn_low_1", o_core_rstn, 3'b000);
        step(1);
        chk("rstn_low_2", o_core_rstn, 3'b000);
        step(RSTC - 1);
        chk("rstn_high", o_core_rstn, 3'b111);
    endtask

    // One-cycle store on the harts in mask, all to the same address.
    task automatic wr(input logic [NH-1:0] mask, input logic [31:0] addr,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        i_wr_valid = mask;
        i_wr_addr  = {addr, addr, addr};
        i_wr_data  = {d2, d1, d0};
        step(1);
        i_wr_valid = '0;
        i_wr_addr  = {$urandom, $urandom, $urandom};
        i_wr_data  = {$urandom, $urandom, $urandom};
    endtask

    task automatic random_run();
        int          guard;
        logic [31:0] lim;
        logic [31:0] a, d;
        lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        start_run(lim);
        guard = 0;
        while ((m_phase == PH_RESET || m_phase == PH_RUN) && guard < 200) begin
            for (int h = 0; h < NH; h++) begin
                i_wr_valid[h] = ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 3))
                    0:       a = 32'h0000_1004;
                    1:       a = $urandom;
                    default: a = TOHOST;
                endcase
                d = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'($urandom_range(0, 15));
                if (guard > 60) begin
                    i_wr_valid[h] = 1'b1;
                    a = TOHOST;
                    d = 32'd1;
                end
                i_wr_addr[h*32 +: 32] = a;
                i_wr_data[h*32 +: 32] = d;
            end
            i_start = ($urandom_range(0, 9) == 0);
            i_rst   = ($urandom_range(0, 299) == 0);
            step(1);
            guard++;
        end
        i_wr_valid = '0;
        i_start    = 1'b0;
        i_rst      = 1'b0;
        if (guard >= 200) chk("rand_term", 64'd0, 64'd1);
        step($urandom_range(1, 3));
    endtask

    initial begin
        i_wr_addr = '0;
        step(3);
        chk_en = 1'b1;
        i_rst  = 1'b0;
        chk("rst_rstn", o_core_rstn, 3'b000);
        chk("rst_done", o_done, 1'b0);
        chk("rst_busy", o_busy, 1'b0);

        // Pass: harts 1,2 finish early, hart 0 writes 1 at RUN cycle 10.
        start_run(32'd0);
        step(3);
        wr(3'b110, TOHOST, 32'd1, 32'd1, 32'd1);
        step(6);
        wr(3'b001, TOHOST, 32'd1, 32'd0, 32'd0);
        chk("A_done",   o_done, 1'b1);
        chk("A_pass",   o_pass, 1'b1);
        chk("A_cycles", o_cycles, 32'd11);

        // Failure with code 7 -> fail_code 3.
        start_run(32'd0);
        step(2);
        wr(3'b110, TOHOST, 32'd1, 32'd1, 32'd1);
        step(2);
        wr(3'b001, TOHOST, 32'd7, 32'd0, 32'd0);
        chk("B_pass",  o_pass, 1'b0);
        chk("B_code",  o_fail_code, 32'd3);
        chk("B_hart",  o_fail_hart, 3'b001);
        chk("B_tmo",   o_timeout, 1'b0);

        // Timeout 50 with no completion.
        start_run(32'd50);
        step(49);
        chk("C_not_yet", o_done, 1'b0);
        step(1);
        chk("C_done",   o_done, 1'b1);
        chk("C_tmo",    o_timeout, 1'b1);
        chk("C_pass",   o_pass, 1'b0);
        chk("C_cycles", o_cycles, 32'd49);
        chk("C_rstn",   o_core_rstn, 3'b000);

        // Harts 2 and 0 fail together, ignored stores, hart 1 finishes.
        start_run(32'd0);
        step(1);
        wr(3'b101, TOHOST, 32'd5, 32'd0, 32'd5);
        step(1);
        wr(3'b010, 32'h0000_1004, 32'd0, 32'd1, 32'd0);
        wr(3'b001, TOHOST, 32'd1, 32'd0, 32'd0);
        chk("D_mid_done", o_done, 1'b0);
        chk("D_mid_hd",   o_hart_done, 3'b101);
        step(1);
        wr(3'b010, TOHOST, 32'd0, 32'd1, 32'd0);
        chk("D_done",   o_done, 1'b1);
        chk("D_hart",   o_fail_hart, 3'b001);
        chk("D_code",   o_fail_code, 32'd2);
        chk("D_pass",   o_pass, 1'b0);
        chk("D_cycles", o_cycles, 32'd7);

        // Last completion lands in the timeout cycle.
        start_run(32'd20);
        step(5);
        wr(3'b011, TOHOST, 32'd1, 32'd1, 32'd0);
        step(13);
        wr(3'b100, TOHOST, 32'd0, 32'd0, 32'd1);
        chk("E_done",   o_done, 1'b1);
        chk("E_tmo",    o_timeout, 1'b0);
        chk("E_pass",   o_pass, 1'b1);
        chk("E_cycles", o_cycles, 32'd20);

        // Start ignored mid-run, then reset aborts the run.
        start_run(32'd0);
        step(4);
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        step(1);
        chk("F_cycles", o_cycles, 32'd6);
        chk("F_busy",   o_busy, 1'b1);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        chk("F_rstn",   o_core_rstn, 3'b000);
        chk("F_busy0",  o_busy, 1'b0);
        chk("F_cyc0",   o_cycles, 32'd0);
        step(2);
        chk("F_idle",   o_busy, 1'b0);

        for (int r = 0; r < 40; r++) random_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
